sdram_p2_arbiter: RTL and testbench

- Sits directly upstream of the SDRAM controller's second port (p2_*).
- Multiplexes two independent clients onto that single toggle-acknowledged port: client 0 is the ROM/config download writer, client 1 is the fast-RAM/auxiliary DMA reader-writer.
- Converts the controller's toggle-style p2_ack into per-client single-cycle ack pulses.
- Latches the request fields so clients see a simple req/ack handshake.

---
 rtl/sdram_p2_arbiter.sv | 145 ++++++++++++++
 tb/tb_sdram_p2_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_p2_arbiter.sv
// Two-client arbiter in front of the SDRAM controller's toggle-acknowledged second port.
// Latency: req seen in IDLE -> ack pulse 3 cycles + controller turnaround; grants at least 4 cycles apart.
// Backpressure: a losing client keeps req high and waits in IDLE; no ack until it is served.
//
// Ports:
//   clk, reset              system clock (shared with controller), async active-high reset
//   cN_req/we/addr/ds/din   client N request level and fields, held until cN_ack
//   cN_dout, cN_ack         client N read data, valid with its one-cycle ack pulse
//   p2_cs/we/addr/ds/din    registered request to the controller, held stable until ack toggle
//   p2_dout, p2_ack         controller read data and per-access toggle
//   timeout_err             sticky: an access was abandoned after TIMEOUT wait cycles
// Build option: SDRAM_P2_ARB_RR_EN selects round-robin on ties (default: client 0 wins).
module sdram_p2_arbiter #(
   parameter int TIMEOUT = 1023,
   parameter int ADDR_W  = 22
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              c0_req,
   input  logic              c0_we,
   input  logic [ADDR_W-1:0] c0_addr,
   input  logic [1:0]        c0_ds,
   input  logic [15:0]       c0_din,
   output logic [15:0]       c0_dout,
   output logic              c0_ack,
   input  logic              c1_req,
   input  logic              c1_we,
   input  logic [ADDR_W-1:0] c1_addr,
   input  logic [1:0]        c1_ds,
   input  logic [15:0]       c1_din,
   output logic [15:0]       c1_dout,
   output logic              c1_ack,
   output logic              p2_cs,
   output logic              p2_we,
   output logic [ADDR_W-1:0] p2_addr,
   output logic [1:0]        p2_ds,
   output logic [15:0]       p2_din,
   input  logic [15:0]       p2_dout,
   input  logic              p2_ack,
   output logic              timeout_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic       grant_q;     // 0 = client 0 owns the current access
   logic       ack_ref_q;   // p2_ack level at grant; any difference means done
   logic [9:0] cnt_q;
   logic       any_req;
   logic       sel;         // winner if a grant is made this cycle
   logic       acked;
   logic       expired;

`ifdef SDRAM_P2_ARB_RR_EN
   logic       last_q;      // client granted most recently
   // On a tie the client not granted last wins.
   assign sel = c1_req & (~c0_req | ~last_q);
`else
   assign sel = c1_req & ~c0_req;
`endif

   assign any_req = c0_req | c1_req;
   assign acked   = (p2_ack != ack_ref_q);
   // Counter is cleared in ISSUE, so this fires on the TIMEOUT-th WAIT cycle.
   assign expired = (cnt_q == TMO_LAST);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (acked || expired) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         grant_q     <= 1'b0;
         ack_ref_q   <= 1'b0;
         cnt_q       <= '0;
         p2_cs       <= 1'b0;
         p2_we       <= 1'b0;
         p2_addr     <= '0;
         p2_ds       <= 2'b11;
         p2_din      <= '0;
         c0_ack      <= 1'b0;
         c1_ack      <= 1'b0;
         c0_dout     <= '0;
         c1_dout     <= '0;
         timeout_err <= 1'b0;
`ifdef SDRAM_P2_ARB_RR_EN
         last_q      <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         c0_ack  <= 1'b0;
         c1_ack  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  p2_cs     <= 1'b1;
                  p2_we     <= sel ? c1_we   : c0_we;
                  p2_addr   <= sel ? c1_addr : c0_addr;
                  p2_ds     <= sel ? c1_ds   : c0_ds;
                  p2_din    <= sel ? c1_din  : c0_din;
                  // Whatever level p2_ack has now (including a stale toggle from
                  // an access cut short by reset) becomes the reference.
                  ack_ref_q <= p2_ack;
                  grant_q   <= sel;
`ifdef SDRAM_P2_ARB_RR_EN
                  last_q    <= sel;
`endif
               end
            end
            ISSUE: cnt_q <= '0;
            WAIT: begin
               // Ack is raised on leaving WAIT so it coincides with dout and DONE.
               if (acked) begin
                  p2_cs <= 1'b0;
                  if (!p2_we) begin
                     if (grant_q) c1_dout <= p2_dout;
                     else         c0_dout <= p2_dout;
                  end
                  if (grant_q) c1_ack <= 1'b1;
                  else         c0_ack <= 1'b1;
               end else if (expired) begin
                  p2_cs       <= 1'b0;
                  timeout_err <= 1'b1;
                  if (grant_q) c1_ack <= 1'b1;
                  else         c0_ack <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 10'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_p2_arbiter.sv
// Self-checking bench for sdram_p2_arbiter with a toggle-ack controller model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sdram_p2_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        c0_req, c0_we, c1_req, c1_we;
   logic [21:0] c0_addr, c1_addr;
   logic [1:0]  c0_ds, c1_ds;
   logic [15:0] c0_din, c1_din;
   logic [15:0] c0_dout, c1_dout;
   logic        c0_ack, c1_ack;
   logic        p2_cs, p2_we;
   logic [21:0] p2_addr;
   logic [1:0]  p2_ds;
   logic [15:0] p2_din, p2_dout;
   logic        p2_ack;
   logic        timeout_err;

   sdram_p2_arbiter #(.TIMEOUT(1023), .ADDR_W(22)) dut (
      .clk(clk), .reset(reset),
      .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_ds(c0_ds), .c0_din(c0_din),
      .c0_dout(c0_dout), .c0_ack(c0_ack),
      .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_ds(c1_ds), .c1_din(c1_din),
      .c1_dout(c1_dout), .c1_ack(c1_ack),
      .p2_cs(p2_cs), .p2_we(p2_we), .p2_addr(p2_addr), .p2_ds(p2_ds), .p2_din(p2_din),
      .p2_dout(p2_dout), .p2_ack(p2_ack), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct {
      int          cl;
      logic        we;
      logic [21:0] addr;
      logic [1:0]  ds;
      logic [15:0] din;
      logic [15:0] dout;
      int          cs_len;
   } exp_t;

   exp_t exp_q[$];

   // Controller model: counts mdl_delay negedges after seeing p2_cs, then toggles p2_ack.
   logic        mdl_en;
   int          mdl_delay;
   logic [15:0] mdl_data;
   logic        mdl_busy;

   initial begin
      int  cyc;
      logic toggled;
      p2_ack   = 1'b1;
      p2_dout  = 16'h0;
      mdl_busy = 1'b0;
      cyc      = 0;
      toggled  = 1'b0;
      forever begin
         @(negedge clk);
         if (!mdl_busy) begin
            if (p2_cs && mdl_en) begin
               mdl_busy = 1'b1;
               cyc      = 0;
               toggled  = 1'b0;
            end
         end else if (!toggled) begin
            cyc++;
            if (cyc == mdl_delay) begin
               p2_ack  = ~p2_ack;
               p2_dout = mdl_data;
               toggled = 1'b1;
            end
         end else if (!p2_cs) begin
            mdl_busy = 1'b0;
         end
      end
   end

   // Monitor: checks p2 fields against the scoreboard head and pops on every ack.
   logic        prev_cs = 1'b0;
   logic        prev_ack0 = 1'b0;
   logic        prev_ack1 = 1'b0;
   int          cs_run = 0;
   int          cs_len_last = 0;
   logic [41:0] snap;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (p2_cs) begin
            if (!prev_cs) begin
               snap   = {p2_we, p2_addr, p2_ds, p2_din};
               cs_run = 1;
               if (exp_q.size() > 0) begin
                  check("p2_we",   64'(p2_we),   64'(exp_q[0].we));
                  check("p2_addr", 64'(p2_addr), 64'(exp_q[0].addr));
                  check("p2_ds",   64'(p2_ds),   64'(exp_q[0].ds));
                  check("p2_din",  64'(p2_din),  64'(exp_q[0].din));
               end
            end else begin
               cs_run++;
               check("p2_stable", 64'({p2_we, p2_addr, p2_ds, p2_din}), 64'(snap));
            end
         end else if (prev_cs) begin
            cs_len_last = cs_run;
         end
         prev_cs = p2_cs;
         if (c0_ack || c1_ack) begin
            check("ack_width", 64'(c1_ack ? prev_ack1 : prev_ack0), 64'(0));
            check("ack_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("ack_client", 64'(c1_ack), 64'(e.cl));
               check("dout", 64'(c1_ack ? c1_dout : c0_dout), 64'(e.dout));
               check("cs_len", 64'(cs_len_last), 64'(e.cs_len));
            end
         end
         prev_ack0 = c0_ack;
         prev_ack1 = c1_ack;
      end
   end

   function automatic exp_t mk(input int cl, input logic we, input logic [21:0] addr,
                               input logic [1:0] ds, input logic [15:0] din,
                               input logic [15:0] dout, input int cs_len);
      exp_t e;
      e.cl = cl; e.we = we; e.addr = addr; e.ds = ds; e.din = din;
      e.dout = dout; e.cs_len = cs_len;
      return e;
   endfunction

   task automatic drive(input int cl, input logic we, input logic [21:0] addr,
                        input logic [1:0] ds, input logic [15:0] din);
      if (cl == 0) begin
         c0_we = we; c0_addr = addr; c0_ds = ds; c0_din = din; c0_req = 1'b1;
      end else begin
         c1_we = we; c1_addr = addr; c1_ds = ds; c1_din = din; c1_req = 1'b1;
      end
   endtask

   // One access from one client; called just after a negedge.
   task automatic do_access(input int cl, input logic we, input logic [21:0] addr,
                            input logic [1:0] ds, input logic [15:0] din,
                            input logic [15:0] exp_dout, input int cs_len, input int budget);
      logic done;
      done = 1'b0;
      exp_q.push_back(mk(cl, we, addr, ds, din, exp_dout, cs_len));
      drive(cl, we, addr, ds, din);
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         if (cl == 0 ? c0_ack : c1_ack) done = 1'b1;
      end
      check("ack_seen", 64'(done), 64'(1));
      c0_req = 1'b0;
      c1_req = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 50 && mdl_busy; i++) @(negedge clk);
      check("model_idle", 64'(mdl_busy), 64'(0));
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int order[4];
      int seen;
      logic hit;
      reset = 1'b1;
      c0_req = 0; c0_we = 0; c0_addr = 0; c0_ds = 2'b11; c0_din = 0;
      c1_req = 0; c1_we = 0; c1_addr = 0; c1_ds = 2'b11; c1_din = 0;
      mdl_en = 1'b1; mdl_delay = 6; mdl_data = 16'hBEEF;

      repeat (3) @(negedge clk);
      check("rst_p2_cs",   64'(p2_cs),   64'(0));
      check("rst_p2_we",   64'(p2_we),   64'(0));
      check("rst_p2_addr", 64'(p2_addr), 64'(0));
      check("rst_p2_ds",   64'(p2_ds),   64'(2'b11));
      check("rst_p2_din",  64'(p2_din),  64'(0));
      check("rst_acks",    64'({c0_ack, c1_ack}), 64'(0));
      check("rst_c0_dout", 64'(c0_dout), 64'(0));
      check("rst_c1_dout", 64'(c1_dout), 64'(0));
      check("rst_tmo",     64'(timeout_err), 64'(0));
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Single read by client 1; p2_ack is 1 out of reset and toggles to 0.
      do_access(1, 1'b0, 22'h012345, 2'b11, 16'h0, 16'hBEEF, 7, 40);
      check("polarity_ack_now", 64'(p2_ack), 64'(0));
      wait_idle();

      // Contention: both clients write, four grants.
`ifdef SDRAM_P2_ARB_RR_EN
      order = '{0, 1, 0, 1};
`else
      order = '{0, 0, 0, 0};
`endif
      mdl_delay = 3;
      for (int k = 0; k < 4; k++) begin
         if (order[k] == 0) exp_q.push_back(mk(0, 1'b1, 22'h000100, 2'b11, 16'h1111, 16'h0, 4));
         else               exp_q.push_back(mk(1, 1'b1, 22'h000200, 2'b10, 16'h2222, 16'hBEEF, 4));
      end
      drive(0, 1'b1, 22'h000100, 2'b11, 16'h1111);
      drive(1, 1'b1, 22'h000200, 2'b10, 16'h2222);
      seen = 0;
      for (int i = 0; i < 200 && seen < 4; i++) begin
         @(negedge clk);
         hit = c0_ack | c1_ack;
         if (hit) seen++;
      end
      c0_req = 1'b0;
      c1_req = 1'b0;
      check("contention_acks", 64'(seen), 64'(4));
      check("contention_left", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
      wait_idle();

      // Write by client 0 with partial byte strobe.
      mdl_delay = 5; mdl_data = 16'h5A5A;
      do_access(0, 1'b1, 22'h000ABC, 2'b01, 16'h00A5, 16'h0, 6, 40);
      check("no_tmo_yet", 64'(timeout_err), 64'(0));
      wait_idle();

      // Timeout: controller never answers.
      mdl_en = 1'b0;
      do_access(1, 1'b0, 22'h2AAAAA, 2'b11, 16'h0, 16'hBEEF, 1024, 1100);
      check("tmo_err", 64'(timeout_err), 64'(1));
      check("tmo_cs",  64'(p2_cs), 64'(0));
      wait_idle();

      // Reset two cycles into WAIT; the late toggle must be absorbed on the next grant.
      mdl_en = 1'b1; mdl_delay = 6; mdl_data = 16'hDEAD;
      exp_q.push_back(mk(0, 1'b0, 22'h3ABCDE, 2'b11, 16'h0, 16'h0, 0));
      drive(0, 1'b0, 22'h3ABCDE, 2'b11, 16'h0);
      hit = 1'b0;
      for (int i = 0; i < 10 && !hit; i++) begin
         @(negedge clk);
         hit = p2_cs;
      end
      check("rstw_cs_seen", 64'(hit), 64'(1));
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("rstw_cs",   64'(p2_cs), 64'(0));
      check("rstw_tmo",  64'(timeout_err), 64'(0));
      check("rstw_ack",  64'({c0_ack, c1_ack}), 64'(0));
      exp_q.delete();
      c0_req = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      wait_idle();
      check("rstw_dout", 64'(c0_dout), 64'(0));

      mdl_delay = 4; mdl_data = 16'h1234;
      do_access(0, 1'b0, 22'h000321, 2'b11, 16'h0, 16'h1234, 5, 40);
      repeat (10) @(negedge clk);
      check("final_queue", 64'(exp_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
